ysyx_23060077_axi_mst_arbiter: RTL and testbench

- Parametrised N-master arbiter sitting between the CPU-side request ports and the ysyx_23060077_axi bridge's cpu_r/cpu_w interface.
- Read and write channels each have an independent grant FSM, selectable as fixed-priority or round-robin.
- Each grant is held for a whole burst, including the last beat.
- A per-channel beat counter checks that the number of beats matches the burst length and reports mismatches.

---
 rtl/ysyx_23060077_axi_mst_arbiter_pkg.sv | 17 +
 rtl/ysyx_23060077_arb_chan.sv | 115 +++++++++++
 rtl/ysyx_23060077_axi_mst_arbiter.sv | 121 ++++++++++++
 tb/tb_ysyx_23060077_axi_mst_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060077_axi_mst_arbiter_pkg.sv
// Shared constants for the CPU-side master arbiter: bus widths, grant FSM encodings
// and priority-mode selectors.
package ysyx_23060077_axi_mst_arbiter_pkg;

  localparam int AXI_ADDR_WIDTH = 32;
  localparam int AXI_DATA_WIDTH = 32;
  localparam int AXI_LEN_WIDTH  = 8;
  localparam int AXI_SIZE_WIDTH = 3;

  localparam int AXI_ARB_STATE_WIDTH = 1;
  localparam logic [AXI_ARB_STATE_WIDTH-1:0] ARB_IDLE = 1'b0;
  localparam logic [AXI_ARB_STATE_WIDTH-1:0] ARB_BUSY = 1'b1;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

endpackage

// File: rtl/ysyx_23060077_arb_chan.sv
// One channel's grant FSM: priority pick, registered one-hot grant held until the last beat,
// 1-cycle arbitration latency, round-robin pointer and burst-length beat check.
module ysyx_23060077_arb_chan
  import ysyx_23060077_axi_mst_arbiter_pkg::*;
#(
  parameter int NUM_MST   = 2,
  parameter int LEN_W     = AXI_LEN_WIDTH,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NUM_MST-1:0]       valid_i,
  input  logic [NUM_MST*LEN_W-1:0] len_i,
  input  logic                     ready_i,
  input  logic                     last_i,
  output logic [NUM_MST-1:0]       grant_o,
  output logic                     len_err_o
);

  localparam int IDX_W = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;

  logic [AXI_ARB_STATE_WIDTH-1:0] state_q, state_d;
  logic [NUM_MST-1:0]             grant_q, grant_d;
  logic [IDX_W-1:0]               ptr_q, ptr_d;
  logic [LEN_W:0]                 cnt_q, cnt_d;
  logic [LEN_W-1:0]               len_q, len_d;
  logic                           err_q, err_d;

  logic [NUM_MST-1:0] cand;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [LEN_W-1:0]   pick_len;
  logic               beat;
  logic               rel;

  assign beat = (state_q == ARB_BUSY) && ready_i;
  assign rel  = beat && last_i;

  // grant_q is zero in IDLE, so masking it only excludes the grantee at release
  always_comb begin : pick
    int j;
    j        = 0;
    cand     = valid_i & ~grant_q;
    pick_vld = |cand;
    pick_idx = '0;
    pick_len = '0;
    if (PRIO_MODE == PRIO_RR) begin
      for (int i = NUM_MST - 1; i >= 0; i--) begin
        j = (int'(ptr_q) + i) % NUM_MST;
        if (cand[j]) begin
          pick_idx = IDX_W'(j);
          pick_len = len_i[j*LEN_W +: LEN_W];
        end
      end
    end else begin
      for (int i = 0; i < NUM_MST; i++) begin
        if (cand[i]) begin
          pick_idx = IDX_W'(i);
          pick_len = len_i[i*LEN_W +: LEN_W];
        end
      end
    end
  end

  always_comb begin : fsm
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    err_d   = 1'b0;
    if ((state_q == ARB_IDLE) || rel) begin
      if (pick_vld) begin
        state_d           = ARB_BUSY;
        grant_d           = '0;
        grant_d[pick_idx] = 1'b1;
        len_d             = pick_len;
        cnt_d             = '0;
        if (PRIO_MODE == PRIO_RR) begin
          ptr_d = (pick_idx == IDX_W'(NUM_MST - 1)) ? '0 : pick_idx + 1'b1;
        end
      end else begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    end else if (beat) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (beat) begin
      err_d = last_i ? (cnt_q != {1'b0, len_q}) : (cnt_q == {1'b0, len_q});
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  assign grant_o   = grant_q;
  assign len_err_o = err_q;

endmodule

// File: rtl/ysyx_23060077_axi_mst_arbiter.sv
// N-master arbiter in front of the bridge cpu_r/cpu_w ports; grant registered 1 cycle after valid,
// bridge ready/last/data routed only to the grantee, grant held for the whole burst.
module ysyx_23060077_axi_mst_arbiter
  import ysyx_23060077_axi_mst_arbiter_pkg::*;
#(
  parameter int NUM_MST   = 2,
  parameter int ADDR_W    = AXI_ADDR_WIDTH,
  parameter int DATA_W    = AXI_DATA_WIDTH,
  parameter int LEN_W     = AXI_LEN_WIDTH,
  parameter int SIZE_W    = AXI_SIZE_WIDTH,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic                      aclk,
  input  logic                      areset_n,

  input  logic [NUM_MST-1:0]        m_r_valid_i,
  input  logic [NUM_MST*ADDR_W-1:0] m_r_addr_i,
  input  logic [NUM_MST*SIZE_W-1:0] m_r_size_i,
  input  logic [NUM_MST*LEN_W-1:0]  m_r_len_i,
  output logic [NUM_MST-1:0]        m_r_ready_o,
  output logic [NUM_MST*DATA_W-1:0] m_r_data_o,
  output logic [NUM_MST-1:0]        m_r_last_o,

  input  logic [NUM_MST-1:0]        m_w_valid_i,
  input  logic [NUM_MST*ADDR_W-1:0] m_w_addr_i,
  input  logic [NUM_MST*DATA_W-1:0] m_w_data_i,
  input  logic [NUM_MST*SIZE_W-1:0] m_w_size_i,
  input  logic [NUM_MST*LEN_W-1:0]  m_w_len_i,
  output logic [NUM_MST-1:0]        m_w_ready_o,
  output logic [NUM_MST-1:0]        m_w_last_o,

  output logic                      s_r_valid_o,
  output logic [ADDR_W-1:0]         s_r_addr_o,
  output logic [SIZE_W-1:0]         s_r_size_o,
  output logic [LEN_W-1:0]          s_r_len_o,
  input  logic                      s_r_ready_i,
  input  logic [DATA_W-1:0]         s_r_data_i,
  input  logic                      s_r_last_i,

  output logic                      s_w_valid_o,
  output logic [ADDR_W-1:0]         s_w_addr_o,
  output logic [DATA_W-1:0]         s_w_data_o,
  output logic [SIZE_W-1:0]         s_w_size_o,
  output logic [LEN_W-1:0]          s_w_len_o,
  input  logic                      s_w_ready_i,
  input  logic                      s_w_last_i,

  output logic [NUM_MST-1:0]        r_grant_o,
  output logic [NUM_MST-1:0]        w_grant_o,
  output logic                      r_len_err_o,
  output logic                      w_len_err_o
);

  // areset_n is active-high despite its name
  ysyx_23060077_arb_chan #(
    .NUM_MST   (NUM_MST),
    .LEN_W     (LEN_W),
    .PRIO_MODE (PRIO_MODE)
  ) u_r_chan (
    .clk_i     (aclk),
    .rst_i     (areset_n),
    .valid_i   (m_r_valid_i),
    .len_i     (m_r_len_i),
    .ready_i   (s_r_ready_i),
    .last_i    (s_r_last_i),
    .grant_o   (r_grant_o),
    .len_err_o (r_len_err_o)
  );

  ysyx_23060077_arb_chan #(
    .NUM_MST   (NUM_MST),
    .LEN_W     (LEN_W),
    .PRIO_MODE (PRIO_MODE)
  ) u_w_chan (
    .clk_i     (aclk),
    .rst_i     (areset_n),
    .valid_i   (m_w_valid_i),
    .len_i     (m_w_len_i),
    .ready_i   (s_w_ready_i),
    .last_i    (s_w_last_i),
    .grant_o   (w_grant_o),
    .len_err_o (w_len_err_o)
  );

  always_comb begin : r_mux
    s_r_valid_o = |(r_grant_o & m_r_valid_i);
    s_r_addr_o  = '0;
    s_r_size_o  = '0;
    s_r_len_o   = '0;
    m_r_data_o  = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (r_grant_o[k]) begin
        s_r_addr_o                  = m_r_addr_i[k*ADDR_W +: ADDR_W];
        s_r_size_o                  = m_r_size_i[k*SIZE_W +: SIZE_W];
        s_r_len_o                   = m_r_len_i[k*LEN_W +: LEN_W];
        m_r_data_o[k*DATA_W +: DATA_W] = s_r_data_i;
      end
    end
    m_r_ready_o = r_grant_o & {NUM_MST{s_r_ready_i}};
    m_r_last_o  = r_grant_o & {NUM_MST{s_r_last_i}};
  end

  always_comb begin : w_mux
    s_w_valid_o = |(w_grant_o & m_w_valid_i);
    s_w_addr_o  = '0;
    s_w_data_o  = '0;
    s_w_size_o  = '0;
    s_w_len_o   = '0;
    for (int k = 0; k < NUM_MST; k++) begin
      if (w_grant_o[k]) begin
        s_w_addr_o = m_w_addr_i[k*ADDR_W +: ADDR_W];
        s_w_data_o = m_w_data_i[k*DATA_W +: DATA_W];
        s_w_size_o = m_w_size_i[k*SIZE_W +: SIZE_W];
        s_w_len_o  = m_w_len_i[k*LEN_W +: LEN_W];
      end
    end
    m_w_ready_o = w_grant_o & {NUM_MST{s_w_ready_i}};
    m_w_last_o  = w_grant_o & {NUM_MST{s_w_last_i}};
  end

endmodule

// File: tb/tb_ysyx_23060077_axi_mst_arbiter.sv
// Directed bench: round-robin and fixed-priority 2-master instances share stimulus,
// plus a 4-master round-robin instance for pointer wrap.
module tb_ysyx_23060077_axi_mst_arbiter;

  logic aclk = 1'b0;
  logic rst;
  always #5 aclk = ~aclk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [1:0]  r_vld;
  logic [63:0] r_addr;
  logic [5:0]  r_size;
  logic [15:0] r_len;
  logic [1:0]  w_vld;
  logic [63:0] w_addr, w_dat;
  logic [5:0]  w_size;
  logic [15:0] w_len;
  logic        s_r_rdy, s_r_last, s_w_rdy, s_w_last;
  logic [31:0] s_r_dat;

  logic [1:0]  a_m_r_rdy, a_m_r_last, a_m_w_rdy, a_m_w_last, a_r_gnt, a_w_gnt;
  logic [63:0] a_m_r_dat;
  logic        a_s_r_vld, a_s_w_vld, a_r_err, a_w_err;
  logic [31:0] a_s_r_addr, a_s_w_addr, a_s_w_dat;
  logic [2:0]  a_s_r_size, a_s_w_size;
  logic [7:0]  a_s_r_len, a_s_w_len;

  logic [1:0]  f_m_r_rdy, f_m_r_last, f_m_w_rdy, f_m_w_last, f_r_gnt, f_w_gnt;
  logic [63:0] f_m_r_dat;
  logic        f_s_r_vld, f_s_w_vld, f_r_err, f_w_err;
  logic [31:0] f_s_r_addr, f_s_w_addr, f_s_w_dat;
  logic [2:0]  f_s_r_size, f_s_w_size;
  logic [7:0]  f_s_r_len, f_s_w_len;

  logic [3:0]   q_vld;
  logic [31:0]  q_len;
  logic         q_rdy, q_last;
  logic [3:0]   q_m_r_rdy, q_m_r_last, q_m_w_rdy, q_m_w_last, q_r_gnt, q_w_gnt;
  logic [127:0] q_m_r_dat;
  logic         q_s_r_vld, q_s_w_vld, q_r_err, q_w_err;
  logic [31:0]  q_s_r_addr, q_s_w_addr, q_s_w_dat;
  logic [2:0]   q_s_r_size, q_s_w_size;
  logic [7:0]   q_s_r_len, q_s_w_len;

  ysyx_23060077_axi_mst_arbiter #(.NUM_MST(2), .PRIO_MODE(1)) dut_rr (
    .aclk(aclk), .areset_n(rst),
    .m_r_valid_i(r_vld), .m_r_addr_i(r_addr), .m_r_size_i(r_size), .m_r_len_i(r_len),
    .m_r_ready_o(a_m_r_rdy), .m_r_data_o(a_m_r_dat), .m_r_last_o(a_m_r_last),
    .m_w_valid_i(w_vld), .m_w_addr_i(w_addr), .m_w_data_i(w_dat), .m_w_size_i(w_size),
    .m_w_len_i(w_len), .m_w_ready_o(a_m_w_rdy), .m_w_last_o(a_m_w_last),
    .s_r_valid_o(a_s_r_vld), .s_r_addr_o(a_s_r_addr), .s_r_size_o(a_s_r_size),
    .s_r_len_o(a_s_r_len), .s_r_ready_i(s_r_rdy), .s_r_data_i(s_r_dat), .s_r_last_i(s_r_last),
    .s_w_valid_o(a_s_w_vld), .s_w_addr_o(a_s_w_addr), .s_w_data_o(a_s_w_dat),
    .s_w_size_o(a_s_w_size), .s_w_len_o(a_s_w_len), .s_w_ready_i(s_w_rdy), .s_w_last_i(s_w_last),
    .r_grant_o(a_r_gnt), .w_grant_o(a_w_gnt), .r_len_err_o(a_r_err), .w_len_err_o(a_w_err)
  );

  ysyx_23060077_axi_mst_arbiter #(.NUM_MST(2), .PRIO_MODE(0)) dut_fx (
    .aclk(aclk), .areset_n(rst),
    .m_r_valid_i(r_vld), .m_r_addr_i(r_addr), .m_r_size_i(r_size), .m_r_len_i(r_len),
    .m_r_ready_o(f_m_r_rdy), .m_r_data_o(f_m_r_dat), .m_r_last_o(f_m_r_last),
    .m_w_valid_i(w_vld), .m_w_addr_i(w_addr), .m_w_data_i(w_dat), .m_w_size_i(w_size),
    .m_w_len_i(w_len), .m_w_ready_o(f_m_w_rdy), .m_w_last_o(f_m_w_last),
    .s_r_valid_o(f_s_r_vld), .s_r_addr_o(f_s_r_addr), .s_r_size_o(f_s_r_size),
    .s_r_len_o(f_s_r_len), .s_r_ready_i(s_r_rdy), .s_r_data_i(s_r_dat), .s_r_last_i(s_r_last),
    .s_w_valid_o(f_s_w_vld), .s_w_addr_o(f_s_w_addr), .s_w_data_o(f_s_w_dat),
    .s_w_size_o(f_s_w_size), .s_w_len_o(f_s_w_len), .s_w_ready_i(s_w_rdy), .s_w_last_i(s_w_last),
    .r_grant_o(f_r_gnt), .w_grant_o(f_w_gnt), .r_len_err_o(f_r_err), .w_len_err_o(f_w_err)
  );

  ysyx_23060077_axi_mst_arbiter #(.NUM_MST(4), .PRIO_MODE(1)) dut_q (
    .aclk(aclk), .areset_n(rst),
    .m_r_valid_i(q_vld), .m_r_addr_i('0), .m_r_size_i('0), .m_r_len_i(q_len),
    .m_r_ready_o(q_m_r_rdy), .m_r_data_o(q_m_r_dat), .m_r_last_o(q_m_r_last),
    .m_w_valid_i('0), .m_w_addr_i('0), .m_w_data_i('0), .m_w_size_i('0),
    .m_w_len_i('0), .m_w_ready_o(q_m_w_rdy), .m_w_last_o(q_m_w_last),
    .s_r_valid_o(q_s_r_vld), .s_r_addr_o(q_s_r_addr), .s_r_size_o(q_s_r_size),
    .s_r_len_o(q_s_r_len), .s_r_ready_i(q_rdy), .s_r_data_i(32'h0), .s_r_last_i(q_last),
    .s_w_valid_o(q_s_w_vld), .s_w_addr_o(q_s_w_addr), .s_w_data_o(q_s_w_dat),
    .s_w_size_o(q_s_w_size), .s_w_len_o(q_s_w_len), .s_w_ready_i(1'b0), .s_w_last_i(1'b0),
    .r_grant_o(q_r_gnt), .w_grant_o(q_w_gnt), .r_len_err_o(q_r_err), .w_len_err_o(q_w_err)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] q_exp [5];
    q_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    rst = 1'b1;
    r_vld = '0; r_addr = '0; r_size = 6'o22; r_len = '0;
    w_vld = '0; w_addr = '0; w_dat = '0; w_size = 6'o22; w_len = '0;
    s_r_rdy = 1'b1; s_r_last = 1'b1; s_r_dat = 32'h1234; s_w_rdy = 1'b0; s_w_last = 1'b0;
    q_vld = '0; q_len = '0; q_rdy = 1'b0; q_last = 1'b0;
    #12;
    chk("rst_r_gnt", a_r_gnt, 2'b00);
    chk("rst_w_gnt", a_w_gnt, 2'b00);
    chk("rst_s_r_vld", a_s_r_vld, 0);
    chk("rst_m_r_rdy", a_m_r_rdy, 2'b00);
    chk("rst_m_r_dat", a_m_r_dat, 64'h0);
    chk("rst_r_err", a_r_err, 0);
    chk("rst_q_gnt", q_r_gnt, 4'b0000);
    rst = 1'b0; s_r_rdy = 1'b0; s_r_last = 1'b0;
    step();

    // both masters at once: RR (ptr 0) takes Icache, fixed takes LSU; direct handover
    r_vld = 2'b11; r_addr = {32'h200, 32'h100}; r_len = 16'h0000;
    #1;
    chk("s2_pre_gnt", a_r_gnt, 2'b00);
    step();
    chk("s2_rr_gnt", a_r_gnt, 2'b01);
    chk("s2_fx_gnt", f_r_gnt, 2'b10);
    chk("s2_rr_addr", a_s_r_addr, 32'h100);
    chk("s2_fx_addr", f_s_r_addr, 32'h200);
    s_r_rdy = 1'b1; s_r_last = 1'b1; s_r_dat = 32'h55;
    #1;
    chk("s2_rr_rdy", a_m_r_rdy, 2'b01);
    chk("s2_fx_rdy", f_m_r_rdy, 2'b10);
    chk("s2_fx_dat", f_m_r_dat, {32'h55, 32'h0});
    step();
    chk("s2_rr_hand", a_r_gnt, 2'b10);
    chk("s2_fx_hand", f_r_gnt, 2'b01);
    chk("s2_rr_nobubble", a_s_r_vld, 1);
    chk("s2_rr_addr2", a_s_r_addr, 32'h200);
    chk("s2_err", a_r_err, 0);
    r_vld = 2'b00;
    step();
    s_r_rdy = 1'b0; s_r_last = 1'b0;
    #1;
    chk("s2_rr_idle", a_r_gnt, 2'b00);
    chk("s2_fx_idle", f_r_gnt, 2'b00);
    step();

    // Icache read, len=3, four beats
    r_vld = 2'b01; r_addr = {32'h0, 32'h1000}; r_len = 16'h0003;
    step();
    chk("s1_gnt", a_r_gnt, 2'b01);
    chk("s1_vld", a_s_r_vld, 1);
    chk("s1_addr", a_s_r_addr, 32'h1000);
    chk("s1_len", a_s_r_len, 8'd3);
    chk("s1_size", a_s_r_size, 3'd2);
    for (int b = 0; b < 4; b++) begin
      s_r_rdy = 1'b1; s_r_dat = 32'hA0 + b; s_r_last = (b == 3);
      #1;
      chk("s1_rdy", a_m_r_rdy, 2'b01);
      chk("s1_dat", a_m_r_dat, {32'h0, 32'hA0 + b});
      chk("s1_last", a_m_r_last, (b == 3) ? 2'b01 : 2'b00);
      step();
      chk("s1_err", a_r_err, 0);
    end
    r_vld = 2'b00; s_r_rdy = 1'b0; s_r_last = 1'b0;
    #1;
    chk("s1_idle", a_r_gnt, 2'b00);
    step();

    // RR pointer now 1: LSU first; then grantee re-wins only through IDLE
    r_vld = 2'b11; r_len = 16'h0000;
    step();
    chk("s2b_rr_gnt", a_r_gnt, 2'b10);
    chk("s2b_fx_gnt", f_r_gnt, 2'b10);
    s_r_rdy = 1'b1; s_r_last = 1'b1;
    step();
    chk("s2b_rr_hand", a_r_gnt, 2'b01);
    r_vld = 2'b01;
    step();
    chk("s2b_rr_idle", a_r_gnt, 2'b00);
    chk("s2b_fx_idle", f_r_gnt, 2'b00);
    s_r_rdy = 1'b0; s_r_last = 1'b0;
    step();
    chk("s2b_rewin", a_r_gnt, 2'b01);
    s_r_rdy = 1'b1; s_r_last = 1'b1; r_vld = 2'b00;
    step();
    s_r_rdy = 1'b0; s_r_last = 1'b0;
    #1;
    chk("s2b_done", a_r_gnt, 2'b00);

    // early last on beat 2 of a len=3 burst
    r_vld = 2'b01; r_len = 16'h0003;
    step();
    s_r_rdy = 1'b1; s_r_last = 1'b0;
    step();
    chk("s3_err_b0", a_r_err, 0);
    s_r_last = 1'b1; r_vld = 2'b00;
    step();
    chk("s3_err", a_r_err, 1);
    chk("s3_rel", a_r_gnt, 2'b00);
    s_r_rdy = 1'b0; s_r_last = 1'b0;
    step();
    chk("s3_err_pulse", a_r_err, 0);

    // missing last at beat 4, late last on beat 5
    r_vld = 2'b01; r_len = 16'h0003;
    step();
    for (int b = 0; b < 4; b++) begin
      s_r_rdy = 1'b1; s_r_last = 1'b0;
      step();
      chk("s3b_err", a_r_err, (b == 3));
      chk("s3b_held", a_r_gnt, 2'b01);
    end
    s_r_last = 1'b1; r_vld = 2'b00;
    step();
    chk("s3b_late_err", a_r_err, 1);
    chk("s3b_rel", a_r_gnt, 2'b00);
    s_r_rdy = 1'b0; s_r_last = 1'b0;
    step();
    chk("s3b_err_pulse", a_r_err, 0);

    // ready while idle is ignored
    s_r_rdy = 1'b1; s_r_last = 1'b1;
    #1;
    chk("idle_m_rdy", a_m_r_rdy, 2'b00);
    step();
    chk("idle_err", a_r_err, 0);
    chk("idle_gnt", a_r_gnt, 2'b00);
    s_r_rdy = 1'b0; s_r_last = 1'b0;

    // valid dropped mid-burst: s_valid follows, grant held until last
    r_vld = 2'b01; r_len = 16'h0001;
    step();
    s_r_rdy = 1'b1;
    step();
    r_vld = 2'b00; s_r_rdy = 1'b0;
    #1;
    chk("drop_vld", a_s_r_vld, 0);
    chk("drop_gnt", a_r_gnt, 2'b01);
    step();
    chk("drop_gnt2", a_r_gnt, 2'b01);
    s_r_rdy = 1'b1; s_r_last = 1'b1;
    step();
    chk("drop_rel", a_r_gnt, 2'b00);
    chk("drop_err", a_r_err, 0);
    s_r_rdy = 1'b0; s_r_last = 1'b0;

    // LSU write concurrent with Icache read
    r_vld = 2'b01; r_len = 16'h0000; r_addr = {32'h0, 32'h1000};
    w_vld = 2'b10; w_addr = {32'h300, 32'h0}; w_dat = {32'hDEAD_BEEF, 32'h0}; w_len = 16'h0000;
    step();
    chk("s4_w_gnt", a_w_gnt, 2'b10);
    chk("s4_r_gnt", a_r_gnt, 2'b01);
    chk("s4_w_vld", a_s_w_vld, 1);
    chk("s4_w_addr", a_s_w_addr, 32'h300);
    chk("s4_w_dat", a_s_w_dat, 32'hDEAD_BEEF);
    s_w_rdy = 1'b1; s_w_last = 1'b1;
    #1;
    chk("s4_m_w_rdy", a_m_w_rdy, 2'b10);
    chk("s4_m_w_last", a_m_w_last, 2'b10);
    step();
    w_vld = 2'b00; s_w_rdy = 1'b0; s_w_last = 1'b0;
    #1;
    chk("s4_w_rel", a_w_gnt, 2'b00);
    chk("s4_r_held", a_r_gnt, 2'b01);
    chk("s4_w_err", a_w_err, 0);
    s_r_rdy = 1'b1; s_r_last = 1'b1; r_vld = 2'b00;
    step();
    chk("s4_r_rel", a_r_gnt, 2'b00);
    s_r_rdy = 1'b0; s_r_last = 1'b0;

    // reset mid-burst after beat 1 of 4
    r_vld = 2'b01; r_len = 16'h0003;
    step();
    s_r_rdy = 1'b1;
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("s5_rst_gnt", a_r_gnt, 2'b00);
    chk("s5_rst_vld", a_s_r_vld, 0);
    chk("s5_rst_rdy", a_m_r_rdy, 2'b00);
    rst = 1'b0; s_r_rdy = 1'b0; r_vld = 2'b11; r_len = 16'h0000;
    step();
    chk("s5_post_rr_gnt", a_r_gnt, 2'b01);
    chk("s5_post_fx_gnt", f_r_gnt, 2'b10);
    s_r_rdy = 1'b1; s_r_last = 1'b1; r_vld = 2'b00;
    step();
    chk("s5_post_err", a_r_err, 0);
    chk("s5_post_rel", a_r_gnt, 2'b00);
    s_r_rdy = 1'b0; s_r_last = 1'b0;

    // four masters, round-robin, single-beat bursts back to back
    q_vld = 4'b1111; q_len = '0; q_rdy = 1'b1; q_last = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("q_gnt", q_r_gnt, q_exp[i]);
      chk("q_rdy", q_m_r_rdy, q_exp[i]);
      step();
      chk("q_err", q_r_err, 0);
    end
    q_vld = 4'b0000;
    step();
    chk("q_idle", q_r_gnt, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
